// File: rtl/fcc_way_arbiter.sv
// fcc_way_arbiter
//   Arbitrates NAND ways for a flash channel controller. Each way runs its own
//   IDLE/WAIT/LOCK/FIN sequence; a round-robin arbiter moves one WAIT way into
//   LOCK at a time. It only does so while no way holds LOCK. Ways in FIN do not
//   block grants, so array operations on different ways overlap.
//
// Parameters
//   WAY_NUM  number of NAND ways (1..8)
//   LOCK_TO  max cycles a way may sit in LOCK with its executer still ready (2..255)
//
// Ports
//   usr_clk        rising-edge clock
//   usr_rst_n      asynchronous active-low reset
//   i_sched_valid  per-way page-command valid from the scheduler
//   o_sched_ready  per-way prefetch ready (registered)
//   i_exec_ready   per-way executer command ready
//   o_exec_valid   per-way one-cycle launch pulse, first cycle of LOCK
//   i_exec_status  per-way executer status, 2 bits per way, 2'h1 = BUSY
//   i_io_busy      per-way flag that the way is driving the NAND bus
//   o_keep_wait    per-way hold request: some other way reports BUSY
//   o_bus_sel      index of the way owning the PHY bus mux
//   o_lock_err     per-way one-cycle LOCK timeout pulse
module fcc_way_arbiter #(
    parameter int unsigned  WAY_NUM = 2,
    parameter int unsigned  LOCK_TO = 16,
    localparam int unsigned WAY_W   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
    input  logic                 usr_clk,
    input  logic                 usr_rst_n,
    input  logic [WAY_NUM-1:0]   i_sched_valid,
    output logic [WAY_NUM-1:0]   o_sched_ready,
    input  logic [WAY_NUM-1:0]   i_exec_ready,
    output logic [WAY_NUM-1:0]   o_exec_valid,
    input  logic [2*WAY_NUM-1:0] i_exec_status,
    input  logic [WAY_NUM-1:0]   i_io_busy,
    output logic [WAY_NUM-1:0]   o_keep_wait,
    output logic [WAY_W-1:0]     o_bus_sel,
    output logic [WAY_NUM-1:0]   o_lock_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOCK,
        ST_FIN
    } state_e;

    // Counter value at which the next increment reaches LOCK_TO.
    localparam logic [7:0]       LOCK_LAST = 8'(LOCK_TO - 1);
    // Pointer starts at the last way so the first search begins at way 0.
    localparam logic [WAY_W-1:0] PTR_RST   = WAY_W'(WAY_NUM - 1);

    state_e             state_q [WAY_NUM];
    state_e             state_d [WAY_NUM];
    logic [7:0]         cnt_q   [WAY_NUM];
    logic [7:0]         cnt_d   [WAY_NUM];
    logic [WAY_W-1:0]   ptr_q, ptr_d;
    logic [WAY_NUM-1:0] sched_ready_q, sched_ready_d;
    logic [WAY_NUM-1:0] exec_valid_q, exec_valid_d;
    logic [WAY_NUM-1:0] keep_wait_q, keep_wait_d;
    logic [WAY_NUM-1:0] lock_err_q, lock_err_d;
    logic [WAY_W-1:0]   bus_sel_q, bus_sel_d;

    logic [WAY_NUM-1:0] grant;
    logic [WAY_NUM-1:0] st_busy;
    logic               any_lock;
    logic               gnt_found;
    logic [WAY_W-1:0]   gnt_idx;
    logic [WAY_W-1:0]   cand;
    logic               bus_found;

    // Round-robin search from ptr+1, wrapping modulo WAY_NUM so non-power-of-two
    // way counts never visit an unused index.
    always_comb begin
        any_lock  = 1'b0;
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        grant     = '0;
        for (int unsigned i = 0; i < WAY_NUM; i++) begin
            if (state_q[i] == ST_LOCK) begin
                any_lock = 1'b1;
            end
        end
        for (int unsigned k = 1; k <= WAY_NUM; k++) begin
            cand = WAY_W'((32'(ptr_q) + k) % WAY_NUM);
            if (!gnt_found && !any_lock && (state_q[cand] == ST_WAIT)) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        for (int unsigned i = 0; i < WAY_NUM; i++) begin
            grant[i] = gnt_found && (32'(gnt_idx) == i);
        end
        ptr_d = gnt_found ? gnt_idx : ptr_q;
    end

    // Per-way sequencing. In LOCK a dropped ready wins over the timeout.
    always_comb begin
        sched_ready_d = '0;
        lock_err_d    = '0;
        exec_valid_d  = grant;
        for (int unsigned i = 0; i < WAY_NUM; i++) begin
            state_d[i]       = state_q[i];
            cnt_d[i]         = cnt_q[i];
            sched_ready_d[i] = (state_q[i] == ST_IDLE) && !i_sched_valid[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (i_sched_valid[i]) begin
                        state_d[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (grant[i]) begin
                        state_d[i] = ST_LOCK;
                        cnt_d[i]   = '0;
                    end
                end
                ST_LOCK: begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                    if (!i_exec_ready[i]) begin
                        state_d[i] = ST_FIN;
                    end else if (cnt_q[i] == LOCK_LAST) begin
                        state_d[i]    = ST_IDLE;
                        lock_err_d[i] = 1'b1;
                    end
                end
                ST_FIN: begin
                    if (i_exec_ready[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Keep-wait excludes the way's own status; bus select takes the lowest
    // busy index and otherwise holds.
    always_comb begin
        st_busy     = '0;
        keep_wait_d = '0;
        bus_sel_d   = bus_sel_q;
        bus_found   = 1'b0;
        for (int unsigned j = 0; j < WAY_NUM; j++) begin
            st_busy[j] = (i_exec_status[2*j +: 2] == 2'h1);
        end
        for (int unsigned i = 0; i < WAY_NUM; i++) begin
            for (int unsigned j = 0; j < WAY_NUM; j++) begin
                if ((j != i) && st_busy[j]) begin
                    keep_wait_d[i] = 1'b1;
                end
            end
        end
        for (int unsigned j = 0; j < WAY_NUM; j++) begin
            if (!bus_found && i_io_busy[j]) begin
                bus_found = 1'b1;
                bus_sel_d = WAY_W'(j);
            end
        end
    end

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            for (int unsigned i = 0; i < WAY_NUM; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            ptr_q         <= PTR_RST;
            sched_ready_q <= '0;
            exec_valid_q  <= '0;
            keep_wait_q   <= '0;
            lock_err_q    <= '0;
            bus_sel_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < WAY_NUM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ptr_q         <= ptr_d;
            sched_ready_q <= sched_ready_d;
            exec_valid_q  <= exec_valid_d;
            keep_wait_q   <= keep_wait_d;
            lock_err_q    <= lock_err_d;
            bus_sel_q     <= bus_sel_d;
        end
    end

    assign o_sched_ready = sched_ready_q;
    assign o_exec_valid  = exec_valid_q;
    assign o_keep_wait   = keep_wait_q;
    assign o_lock_err    = lock_err_q;
    assign o_bus_sel     = bus_sel_q;

endmodule

// File: tb/tb_fcc_way_arbiter.sv
// Testbench for fcc_way_arbiter: a 2-way instance driven by directed steps
// and a 3-way instance (short lock timeout) checked every cycle against a
// behavioural model.
module tb_fcc_way_arbiter;

    localparam int N3     = 3;
    localparam int LT3    = 3;
    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_LOCK = 2;
    localparam int P_FIN  = 3;

    logic       clk;
    logic       rst_n;

    logic [1:0] sv2, sr2, er2, ev2, iob2, kw2, le2;
    logic [3:0] st2;
    logic [0:0] bs2;

    logic [2:0] sv3, sr3, er3, ev3, iob3, kw3, le3;
    logic [5:0] st3;
    logic [1:0] bs3;

    int n_assert = 0;
    int n_fail   = 0;
    bit rand3    = 0;

    // model state for the 3-way instance
    int         m_ph  [3];
    int         m_age [3];
    int         m_last;
    logic [2:0] e_sr, e_ev, e_kw, e_le;
    logic [1:0] e_bs;

    int order[$];
    int exp_ord [6] = '{0, 1, 2, 0, 1, 2};

    fcc_way_arbiter #(.WAY_NUM(2), .LOCK_TO(16)) u_dut2 (
        .usr_clk       (clk),
        .usr_rst_n     (rst_n),
        .i_sched_valid (sv2),
        .o_sched_ready (sr2),
        .i_exec_ready  (er2),
        .o_exec_valid  (ev2),
        .i_exec_status (st2),
        .i_io_busy     (iob2),
        .o_keep_wait   (kw2),
        .o_bus_sel     (bs2),
        .o_lock_err    (le2)
    );

    fcc_way_arbiter #(.WAY_NUM(N3), .LOCK_TO(LT3)) u_dut3 (
        .usr_clk       (clk),
        .usr_rst_n     (rst_n),
        .i_sched_valid (sv3),
        .o_sched_ready (sr3),
        .i_exec_ready  (er3),
        .o_exec_valid  (ev3),
        .i_exec_status (st3),
        .i_io_busy     (iob3),
        .o_keep_wait   (kw3),
        .o_bus_sel     (bs3),
        .o_lock_err    (le3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N3; i++) begin
            m_ph[i]  = P_IDLE;
            m_age[i] = 0;
        end
        m_last = N3 - 1;
        e_sr = '0; e_ev = '0; e_kw = '0; e_le = '0; e_bs = '0;
    endtask

    // One clock of the 3-way behaviour, from the inputs driven this cycle.
    task automatic model_update();
        int  g;
        int  w;
        int  nbusy;
        int  own;
        bit  locked;
        g = -1; locked = 0; nbusy = 0;
        for (int i = 0; i < N3; i++) if (m_ph[i] == P_LOCK) locked = 1;
        if (!locked) begin
            for (int k = 1; k <= N3; k++) begin
                w = (m_last + k) % N3;
                if (g < 0 && m_ph[w] == P_WAIT) g = w;
            end
        end
        if (g >= 0) m_last = g;
        for (int j = 0; j < N3; j++) if (st3[2*j +: 2] == 2'h1) nbusy++;
        for (int j = N3 - 1; j >= 0; j--) if (iob3[j]) e_bs = 2'(j);
        for (int i = 0; i < N3; i++) begin
            own     = (st3[2*i +: 2] == 2'h1) ? 1 : 0;
            e_sr[i] = (m_ph[i] == P_IDLE) && !sv3[i];
            e_ev[i] = (g == i);
            e_kw[i] = (nbusy - own) > 0;
            e_le[i] = 1'b0;
            case (m_ph[i])
                P_IDLE: if (sv3[i]) m_ph[i] = P_WAIT;
                P_WAIT: if (g == i) begin m_ph[i] = P_LOCK; m_age[i] = 0; end
                P_LOCK: begin
                    m_age[i]++;
                    if (!er3[i]) m_ph[i] = P_FIN;
                    else if (m_age[i] == LT3) begin m_ph[i] = P_IDLE; e_le[i] = 1'b1; end
                end
                P_FIN:  if (er3[i]) m_ph[i] = P_IDLE;
                default: m_ph[i] = P_IDLE;
            endcase
        end
    endtask

    task automatic check3();
        chk("d3_sched_ready", 32'(sr3), 32'(e_sr));
        chk("d3_exec_valid",  32'(ev3), 32'(e_ev));
        chk("d3_keep_wait",   32'(kw3), 32'(e_kw));
        chk("d3_bus_sel",     32'(bs3), 32'(e_bs));
        chk("d3_lock_err",    32'(le3), 32'(e_le));
    endtask

    // Called at a negedge with this cycle's inputs driven; returns at the next negedge.
    task automatic step();
        st3  = 6'($urandom);
        iob3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        if (rand3) begin
            sv3 = 3'($urandom);
            for (int i = 0; i < N3; i++) er3[i] = ($urandom_range(0, 3) != 0);
        end
        if (rst_n) model_update();
        @(posedge clk);
        @(negedge clk);
        check3();
    endtask

    task automatic chk_dut2_zero(input string tag);
        chk({tag, "_sr"}, 32'(sr2), 32'h0);
        chk({tag, "_ev"}, 32'(ev2), 32'h0);
        chk({tag, "_kw"}, 32'(kw2), 32'h0);
        chk({tag, "_bs"}, 32'(bs2), 32'h0);
        chk({tag, "_le"}, 32'(le2), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        sv2 = '0; er2 = '1; st2 = '0; iob2 = '0;
        sv3 = '0; er3 = '1; st3 = '0; iob3 = '0;
        model_reset();
        @(negedge clk);
        repeat (2) step();
        chk_dut2_zero("reset");

        // cold start: ready rises on the second cycle after release
        rst_n = 1'b1;
        chk("boot_sr_r0", 32'(sr2), 32'h0);
        step();
        chk("boot_sr_r1", 32'(sr2), 32'h3);
        chk("boot_ev_r1", 32'(ev2), 32'h0);
        step();
        chk("boot_sr_r2", 32'(sr2), 32'h3);
        chk("boot_ev_r2", 32'(ev2), 32'h0);

        // both ways valid together; executers drop ready 2 cycles after launch for 5
        sv2 = 2'b11; er2 = 2'b11; st2 = 4'b0101; iob2 = 2'b10;
        step();
        for (int c = 1; c <= 10; c++) begin
            chk("ovl_exec_valid", 32'(ev2), (c == 2) ? 32'h1 : (c == 6) ? 32'h2 : 32'h0);
            sv2 = '0; iob2 = '0;
            er2[0] = !(c >= 4 && c <= 8);
            er2[1] = !(c >= 8 && c <= 12);
            if (c < 10) step();
        end
        chk("pre_rst_kw", 32'(kw2), 32'h3);
        chk("pre_rst_bs", 32'(bs2), 32'h1);

        // asynchronous reset while way 1 is in FIN
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_dut2_zero("async_rst");
        check3();
        er2 = '1; st2 = '0;
        step();
        chk_dut2_zero("rst_hold");
        rst_n = 1'b1;
        step();
        chk("post_rst_sr", 32'(sr2), 32'h3);
        chk("post_rst_le", 32'(le2), 32'h0);

        // both valid, executers never accept: way 0 first, each times out after 16
        sv2 = 2'b11;
        step();
        for (int c = 1; c <= 36; c++) begin
            chk("to_exec_valid", 32'(ev2), (c == 2) ? 32'h1 : (c == 19) ? 32'h2 : 32'h0);
            chk("to_lock_err",   32'(le2), (c == 18) ? 32'h1 : (c == 35) ? 32'h2 : 32'h0);
            chk("to_sched_ready", 32'(sr2), {30'h0, (c >= 36) ? 1'b1 : 1'b0, (c >= 19) ? 1'b1 : 1'b0});
            sv2 = '0;
            if (c < 36) step();
        end

        // keep-wait and bus-select
        st2 = 4'b0100; step(); chk("kw_w1busy", 32'(kw2), 32'h1);
        st2 = 4'b0001; step(); chk("kw_w0busy", 32'(kw2), 32'h2);
        st2 = 4'b1001; step(); chk("kw_st2_not_busy", 32'(kw2), 32'h2);
        st2 = 4'b0000; step(); chk("kw_none", 32'(kw2), 32'h0);
        iob2 = 2'b10;  step(); chk("bs_w1", 32'(bs2), 32'h1);
        iob2 = 2'b00;  step(); chk("bs_hold1", 32'(bs2), 32'h1);
        iob2 = 2'b11;  step(); chk("bs_lowest", 32'(bs2), 32'h0);
        iob2 = 2'b00;  step(); chk("bs_hold0", 32'(bs2), 32'h0);

        // 3 ways, all valid, executers acknowledge on the launch cycle
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N3; i++) if (ev3[i]) order.push_back(i);
            sv3 = '1;
            er3 = ~ev3;
            step();
        end
        chk("rr_count_ge6", 32'(order.size() >= 6), 32'h1);
        for (int k = 0; k < 6; k++) chk("rr_order", 32'(order[k]), 32'(exp_ord[k]));

        // randomized traffic on the 3-way instance, with one reset mid-run
        rand3 = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check3();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fcc_way_arbiter.md
FCC_WAY_ARBITER -- requirements
Module: fcc_way_arbiter

Interface
REQ-001 The block SHALL have parameter WAY_NUM, default 2, meaning the number of NAND ways (legal range 1..8).
REQ-002 The block SHALL have parameter LOCK_TO, default 16, meaning the maximum number of cycles a way waits in LOCK for its executer to accept (range 2..255).
REQ-003 The block SHALL define derived width WAY_W = max(1, clog2(WAY_NUM)).
REQ-004 Port usr_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port usr_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port i_sched_valid, input, WAY_NUM bits: per-way page-command valid from the scheduler.
REQ-007 Port o_sched_ready, output, WAY_NUM bits: per-way prefetch ready to the scheduler.
REQ-008 Port i_exec_ready, input, WAY_NUM bits: per-way executer command ready.
REQ-009 Port o_exec_valid, output, WAY_NUM bits: per-way command launch to the executer.
REQ-010 Port i_exec_status, input, 2*WAY_NUM bits: per-way executer status; way i occupies bits [2i+1:2i], and 2'h1 = BUSY.
REQ-011 Port i_io_busy, input, WAY_NUM bits: per-way flag that the way is driving the NAND bus.
REQ-012 Port o_keep_wait, output, WAY_NUM bits: per-way hold request to the executer.
REQ-013 Port o_bus_sel, output, WAY_W bits: index of the way owning the PHY bus mux.
REQ-014 Port o_lock_err, output, WAY_NUM bits: per-way one-cycle LOCK-timeout pulse.

Function
REQ-015 Each way SHALL run an independent FSM with states IDLE, WAIT, LOCK and FIN.
- IDLE->WAIT when i_sched_valid[i]=1.
- WAIT->LOCK on the edge at which way i is granted.
- LOCK->FIN when i_exec_ready[i]=0.
- FIN->IDLE when i_exec_ready[i]=1.
REQ-016 Each way SHALL have an 8-bit lock counter.
- Cleared on entry to LOCK; increments each cycle in LOCK.
- If it reaches LOCK_TO while i_exec_ready[i] is still 1, the way SHALL go LOCK->IDLE and pulse o_lock_err[i] for exactly one cycle.
- If i_exec_ready[i]=0 in the same cycle the count reaches LOCK_TO, LOCK->FIN takes priority and no error is flagged.
REQ-017 o_sched_ready[i] SHALL be registered: 1 in the cycle after a cycle with way i in IDLE and i_sched_valid[i]=0, otherwise 0.
REQ-018 Eligible ways are those in WAIT; a grant SHALL issue only when no way is in LOCK, so at most one way is in LOCK at any time.
REQ-019 Arbitration SHALL be round-robin.
- The search starts at (last granted index + 1) mod WAY_NUM.
- At most one grant per cycle.
- The pointer updates only on a grant.
REQ-020 o_exec_valid[i] SHALL be a registered one-cycle pulse, asserted in the cycle after way i's grant edge, i.e. the first cycle of LOCK.
REQ-021 o_keep_wait[i] SHALL be registered, equal to the OR over all j≠i of (status_j == 2'h1); with WAY_NUM=1 it SHALL be constant 0.
REQ-022 o_bus_sel SHALL be registered and load the lowest index j with i_io_busy[j]=1.
- If no way has i_io_busy set, it holds its value.
- If several ways are set simultaneously, the lowest index wins.
REQ-023 Ways in FIN SHALL NOT block grants to other ways, so array operations on different ways overlap.
REQ-024 All width arithmetic SHALL be unsigned; the round-robin index SHALL wrap modulo WAY_NUM, including non-power-of-two WAY_NUM.

Reset
REQ-025 On usr_rst_n=0, asynchronously:
- all FSMs go to IDLE;
- round-robin pointer = WAY_NUM-1, so way 0 is served first;
- lock counters = 0;
- o_sched_ready = 0, o_exec_valid = 0, o_keep_wait = 0, o_lock_err = 0, o_bus_sel = 0.
REQ-026 A reset asserted mid-operation SHALL abandon any LOCK or FIN without an error pulse; after release, ways behave as from cold reset.

Verification
REQ-027 WAY_NUM=2. Release reset with i_sched_valid=0 -> o_sched_ready=2'b11 from the second cycle after release; o_exec_valid=0 throughout.
REQ-028 i_sched_valid=2'b11 in the same cycle, executers answer ready-low 2 cycles after launch, then ready-high 5 cycles later -> way 0 is granted first; way 1's o_exec_valid pulse follows only after way 0 reaches FIN.
REQ-029 WAY_NUM=3, all ways valid repeatedly, executers acknowledge quickly -> the grant order is 0,1,2,0,1,2.
REQ-030 LOCK_TO=16, i_exec_ready[0] held 1 after launch -> o_lock_err[0] pulses once, 16 cycles after LOCK entry, and way 0 returns to IDLE.
REQ-031 i_exec_status way1 = 2'h1 -> o_keep_wait = 2'b01 one cycle later; i_io_busy = 2'b11 -> o_bus_sel = 0; then i_io_busy = 0 -> o_bus_sel stays 0.
REQ-032 Drop usr_rst_n while way 1 is in FIN -> all outputs are 0 immediately; no o_lock_err pulse; the first grant after release goes to way 0.
